// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / LS) arbiter and sequencer for the single memory port.
// Define ARB_STARVE_GUARD_EN to build the IF starvation guard (starve_cnt + forced IF selection).
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [1:0]      ls_size,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            arb_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS
    } state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_t state_q, state_d;
    logic   store_q, store_d;
    logic   arb_err_q, arb_err_d;
    logic   force_if;
    logic   sel_if, sel_ls;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb force_if = if_req && (starve_cnt_q == LIMIT);
`else
    always_comb force_if = 1'b0;
`endif

    // Selection is live only in IDLE and is suppressed while reset is held,
    // so every output reads zero during reset.
    always_comb begin
        sel_if = 1'b0;
        sel_ls = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (force_if) begin
                sel_if = 1'b1;
            end else if (ls_req) begin
                sel_ls = 1'b1;
            end else if (if_req) begin
                sel_if = 1'b1;
            end
        end
    end

    always_comb begin
        mem_req   = sel_if || sel_ls;
        mem_we    = sel_ls && ls_we;
        mem_size  = sel_ls ? ls_size : (sel_if ? 2'd2 : 2'd0);
        mem_addr  = sel_ls ? ls_addr : (sel_if ? if_addr : '0);
        mem_wdata = sel_ls ? ls_wdata : '0;

        if_gnt    = sel_if && mem_gnt;
        ls_gnt    = sel_ls && mem_gnt;

        if_rvalid = !rst && state_q == BUSY_IF && mem_rvalid;
        ls_rvalid = !rst && state_q == BUSY_LS && mem_rvalid;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = (ls_rvalid && !store_q) ? mem_rdata : '0;

        arb_err   = arb_err_q;
    end

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        arb_err_d = (state_q == IDLE) && mem_rvalid;
        unique case (state_q)
            IDLE: begin
                if (ls_gnt) begin
                    state_d = BUSY_LS;
                    store_d = ls_we;
                end else if (if_gnt) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt) begin
            starve_cnt_d = '0;
        end else if (sel_ls && if_req && starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            arb_err_q    <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            arb_err_q    <= arb_err_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-table bench for mem_port_arbiter; one record per clock cycle, plus a starvation sequence.
module tb_mem_port_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OW   = 137;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic            if_gnt, if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req = 1'b0, ls_we = 1'b0;
    logic [1:0]      ls_size = '0;
    logic [XLEN-1:0] ls_addr = '0, ls_wdata = '0;
    logic            ls_gnt, ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_req, mem_we;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            rst;
        logic            ifr;
        logic [31:0]     ifa;
        logic            lsr, lswe;
        logic [1:0]      lssz;
        logic [31:0]     lsa, lsw;
        logic            mg, mrv;
        logic [31:0]     mrd;
        logic [OW-1:0]   exp;
    } vec_t;

    vec_t vecs[$];

    // Expected-output packer: field order matches act() below.
    function automatic logic [OW-1:0] ex(
        input logic ig, irv, input logic [31:0] ird,
        input logic lg, lrv, input logic [31:0] lrd,
        input logic mr, mwe, input logic [1:0] msz,
        input logic [31:0] ma, mw, input logic ae);
        return {ig, irv, ird, lg, lrv, lrd, mr, mwe, msz, ma, mw, ae};
    endfunction

    function automatic logic [OW-1:0] act();
        return {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                mem_req, mem_we, mem_size, mem_addr, mem_wdata, arb_err};
    endfunction

    function automatic vec_t mk(
        input string n, input logic r, ifr, input logic [31:0] ifa,
        input logic lsr, lswe, input logic [1:0] lssz, input logic [31:0] lsa, lsw,
        input logic mg, mrv, input logic [31:0] mrd, input logic [OW-1:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.lswe = lswe;
        v.lssz = lssz; v.lsa = lsa; v.lsw = lsw; v.mg = mg; v.mrv = mrv; v.mrd = mrd;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.rst; if_req = v.ifr; if_addr = v.ifa;
        ls_req = v.lsr; ls_we = v.lswe; ls_size = v.lssz; ls_addr = v.lsa; ls_wdata = v.lsw;
        mem_gnt = v.mg; mem_rvalid = v.mrv; mem_rdata = v.mrd;
        @(negedge clk);
        chk(v.name, act(), v.exp);
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = '0; ls_addr = '0; ls_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    logic [OW-1:0] z;
    logic          guard;
    logic          exp_if;

    initial begin
        z = '0;
`ifdef ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        //           name            rst ifr ifa     lsr we sz lsa     lsw    mg mrv mrd
        vecs.push_back(mk("reset_hold",   1, 1, 'h100, 1, 1, 2, 'h200, 'h55, 1, 1, 'h1, z));
        vecs.push_back(mk("fetch_gnt",    0, 1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0,
                          ex(1,0,0, 0,0,0, 1,0,2,'h100,0, 0)));
        vecs.push_back(mk("fetch_wait",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, z));
        vecs.push_back(mk("fetch_resp",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hDEADBEEF,
                          ex(0,1,'hDEADBEEF, 0,0,0, 0,0,0,0,0, 0)));
        vecs.push_back(mk("contend_ls",   0, 1, 'h104, 1, 1, 2, 'h200, 'h55, 1, 0, 0,
                          ex(0,0,0, 1,0,0, 1,1,2,'h200,'h55, 0)));
        vecs.push_back(mk("contend_busy", 0, 1, 'h104, 0, 0, 0, 0, 0, 1, 0, 0, z));
        vecs.push_back(mk("store_ack",    0, 1, 'h104, 0, 0, 0, 0, 0, 1, 1, 'h12345678,
                          ex(0,0,0, 0,1,0, 0,0,0,0,0, 0)));
        vecs.push_back(mk("if_after_ls",  0, 1, 'h104, 0, 0, 0, 0, 0, 1, 0, 0,
                          ex(1,0,0, 0,0,0, 1,0,2,'h104,0, 0)));
        vecs.push_back(mk("fetch2_resp",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hCAFEF00D,
                          ex(0,1,'hCAFEF00D, 0,0,0, 0,0,0,0,0, 0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("backpressure", 0, 0, 0, 1, 0, 1, 'h300, 0, 0, 0, 0,
                              ex(0,0,0, 0,0,0, 1,0,1,'h300,0, 0)));
        vecs.push_back(mk("bp_grant",     0, 0, 0, 1, 0, 1, 'h300, 0, 1, 0, 0,
                          ex(0,0,0, 1,0,0, 1,0,1,'h300,0, 0)));
        vecs.push_back(mk("load_resp",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0000BEEF,
                          ex(0,0,0, 0,1,'h0000BEEF, 0,0,0,0,0, 0)));
        vecs.push_back(mk("if_pending",   0, 1, 'h400, 0, 0, 0, 0, 0, 0, 0, 0,
                          ex(0,0,0, 0,0,0, 1,0,2,'h400,0, 0)));
        vecs.push_back(mk("ls_displaces", 0, 1, 'h400, 1, 0, 0, 'h500, 0, 1, 0, 0,
                          ex(0,0,0, 1,0,0, 1,0,0,'h500,0, 0)));
        vecs.push_back(mk("byte_resp",    0, 1, 'h400, 0, 0, 0, 0, 0, 1, 1, 'hA5,
                          ex(0,0,0, 0,1,'hA5, 0,0,0,0,0, 0)));
        vecs.push_back(mk("if_late_gnt",  0, 1, 'h400, 0, 0, 0, 0, 0, 1, 0, 0,
                          ex(1,0,0, 0,0,0, 1,0,2,'h400,0, 0)));
        vecs.push_back(mk("if_late_resp", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h1,
                          ex(0,1,'h1, 0,0,0, 0,0,0,0,0, 0)));
        vecs.push_back(mk("spurious",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFFFFFF, z));
        vecs.push_back(mk("spurious_err", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          ex(0,0,0, 0,0,0, 0,0,0,0,0, 1)));
        vecs.push_back(mk("err_clear",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, z));
        vecs.push_back(mk("rm_gnt",       0, 0, 0, 1, 0, 2, 'h600, 0, 1, 0, 0,
                          ex(0,0,0, 1,0,0, 1,0,2,'h600,0, 0)));
        vecs.push_back(mk("rm_rst",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, z));
        vecs.push_back(mk("rm_late_resp", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h11111111, z));
        vecs.push_back(mk("rm_err",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                          ex(0,0,0, 0,0,0, 0,0,0,0,0, 1)));
        vecs.push_back(mk("rm_regrant",   0, 0, 0, 1, 0, 2, 'h700, 0, 1, 0, 0,
                          ex(0,0,0, 1,0,0, 1,0,2,'h700,0, 0)));
        vecs.push_back(mk("rm_resp",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h22,
                          ex(0,0,0, 0,1,'h22, 0,0,0,0,0, 0)));

        foreach (vecs[i]) apply(vecs[i]);

        drive_idle();

        // IF held high, LS re-requests every IDLE cycle; memory answers one cycle after grant.
        for (int r = 0; r < 6; r++) begin
            exp_if = guard && (r == 4);
            @(posedge clk);
            #1;
            if_req = 1'b1; if_addr = 'h800;
            ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 'h900;
            mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
            @(negedge clk);
            chk($sformatf("starve_gnt_%0d", r), OW'({if_gnt, ls_gnt, mem_addr}),
                OW'({exp_if, !exp_if, (exp_if ? 32'h800 : 32'h900)}));
            @(posedge clk);
            #1;
            mem_rvalid = 1'b1; mem_rdata = 32'(r + 1);
            @(negedge clk);
            chk($sformatf("starve_resp_%0d", r), OW'({if_rvalid, ls_rvalid, mem_req}),
                OW'({exp_if, !exp_if, 1'b0}));
        end

        drive_idle();
        @(negedge clk);
        chk("final_idle", act(), z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
